// File: rtl/scan_chain_controller_pkg.sv
// Shared constants and types for the scan chain controller and its wrappers.
package scan_chain_controller_pkg;

  localparam int unsigned NUM_IOS = 8;

  typedef enum logic [2:0] {
    SHIFT_IN,
    LATCH,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_e;

  // Step counter width: enough to hold N = num_designs * NUM_IOS.
  function automatic int unsigned step_width(input int unsigned num_designs);
    return $clog2(num_designs * NUM_IOS + 1);
  endfunction

endpackage

// File: rtl/scan_chain_controller_if.sv
// Serial scan bus between the controller and the wrapper daisy chain.
interface scan_chain_controller_if;

  logic scan_clk;
  logic scan_data_out;
  logic scan_data_in;
  logic scan_select;
  logic scan_latch_enable;

  modport master (
    output scan_clk,
    output scan_data_out,
    output scan_select,
    output scan_latch_enable,
    input  scan_data_in
  );

  modport slave (
    input  scan_clk,
    input  scan_data_out,
    input  scan_select,
    input  scan_latch_enable,
    output scan_data_in
  );

endinterface

// File: rtl/scan_wrapper_core.sv
// Generic 8-flop scan wrapper: shift chain, latch into the design input
// register, capture design outputs, and pass strobes down the chain.
module scan_wrapper_core
  import scan_chain_controller_pkg::*;
(
  input  logic               clk_in,
  input  logic               data_in,
  input  logic               scan_select_in,
  input  logic               latch_enable_in,
  output logic               clk_out,
  output logic               data_out,
  output logic               scan_select_out,
  output logic               latch_enable_out,
  output logic [NUM_IOS-1:0] design_in,
  input  logic [NUM_IOS-1:0] design_out
);

  logic [NUM_IOS-1:0] chain_q, chain_d;
  logic [NUM_IOS-1:0] in_reg_q, in_reg_d;

  assign clk_out          = clk_in;
  assign scan_select_out  = scan_select_in;
  assign latch_enable_out = latch_enable_in;
  assign data_out         = chain_q[NUM_IOS-1];
  assign design_in        = in_reg_q;

  // Latch has priority over capture, capture over shift.
  always_comb begin
    chain_d  = chain_q;
    in_reg_d = in_reg_q;
    if (latch_enable_in) begin
      in_reg_d = chain_q;
    end else if (scan_select_in) begin
      chain_d = design_out;
    end else begin
      chain_d = {chain_q[NUM_IOS-2:0], data_in};
    end
  end

  // Chain and input register advance on the scan clock; no reset pin.
  always_ff @(posedge clk_in) begin
    chain_q  <= chain_d;
    in_reg_q <= in_reg_d;
  end

endmodule

// File: rtl/scan_wrapper_lesson_1.sv
// Lesson 1 wrapper: the design core loops its input register straight back.
module scan_wrapper_lesson_1
  import scan_chain_controller_pkg::*;
(
  input  logic clk_in,
  input  logic data_in,
  input  logic scan_select_in,
  input  logic latch_enable_in,
  output logic clk_out,
  output logic data_out,
  output logic scan_select_out,
  output logic latch_enable_out
);

  logic [NUM_IOS-1:0] core_in;
  logic [NUM_IOS-1:0] core_out;

  assign core_out = core_in;

  scan_wrapper_core u_core (
    .clk_in           (clk_in),
    .data_in          (data_in),
    .scan_select_in   (scan_select_in),
    .latch_enable_in  (latch_enable_in),
    .clk_out          (clk_out),
    .data_out         (data_out),
    .scan_select_out  (scan_select_out),
    .latch_enable_out (latch_enable_out),
    .design_in        (core_in),
    .design_out       (core_out)
  );

endmodule

// File: rtl/scan_wrapper_lesson_2.sv
// Lesson 2 wrapper: the design core inverts its input register.
module scan_wrapper_lesson_2
  import scan_chain_controller_pkg::*;
(
  input  logic clk_in,
  input  logic data_in,
  input  logic scan_select_in,
  input  logic latch_enable_in,
  output logic clk_out,
  output logic data_out,
  output logic scan_select_out,
  output logic latch_enable_out
);

  logic [NUM_IOS-1:0] core_in;
  logic [NUM_IOS-1:0] core_out;

  assign core_out = ~core_in;

  scan_wrapper_core u_core (
    .clk_in           (clk_in),
    .data_in          (data_in),
    .scan_select_in   (scan_select_in),
    .latch_enable_in  (latch_enable_in),
    .clk_out          (clk_out),
    .data_out         (data_out),
    .scan_select_out  (scan_select_out),
    .latch_enable_out (latch_enable_out),
    .design_in        (core_in),
    .design_out       (core_out)
  );

endmodule

// File: rtl/scan_chain_controller.sv
// Round-robin scan chain controller: shift in, latch, capture, shift out,
// then present the selected design's result with a one-cycle ready pulse.
module scan_chain_controller
  import scan_chain_controller_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8:0]             active_select,
  input  logic [NUM_IOS-1:0]     inputs,
  output logic [NUM_IOS-1:0]     outputs,
  output logic                   ready,
  scan_chain_controller_if.master scan
);

  localparam int unsigned N      = NUM_DESIGNS * NUM_IOS;
  localparam int unsigned STEP_W = step_width(NUM_DESIGNS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                phase_q, phase_d;

  logic [NUM_IOS-1:0]  inp_q, inp_d;
  logic [8:0]          sel_q, sel_d;
  logic [NUM_IOS-1:0]  result_q, result_d;
  logic [NUM_IOS-1:0]  outputs_q, outputs_d;
  logic                ready_q, ready_d;

  logic [31:0]         pos;
  logic                pos_hit;
  logic [2:0]          bit_idx;

  logic                sclk, sdo, ssel, slat;

  // Chain position addressed by the current step, and whether it belongs
  // to the selected design.
  assign pos     = 32'(N - 1) - 32'(step_q);
  assign pos_hit = (pos[31:3] == 29'(sel_q));
  assign bit_idx = pos[2:0];

  // State register: step/phase sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHIFT_IN;
      step_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

  // Next state: every step is two clk cycles, DONE is a single cycle.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = ~phase_q;
    case (state_q)
      SHIFT_IN: begin
        if (phase_q) begin
          if (step_q == LAST_STEP) begin
            state_d = LATCH;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      LATCH: begin
        if (phase_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (phase_q) state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        if (phase_q) begin
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      DONE: begin
        state_d = SHIFT_IN;
        phase_d = 1'b0;
      end
      default: begin
        state_d = SHIFT_IN;
        step_d  = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // Scan bus outputs decoded from state; scan_clk is the phase bit.
  always_comb begin
    sclk = 1'b0;
    sdo  = 1'b0;
    ssel = 1'b0;
    slat = 1'b0;
    case (state_q)
      SHIFT_IN: begin
        sclk = phase_q;
        sdo  = pos_hit & inp_q[bit_idx];
      end
      LATCH: begin
        sclk = phase_q;
        slat = 1'b1;
      end
      CAPTURE: begin
        sclk = phase_q;
        ssel = 1'b1;
      end
      SHIFT_OUT: begin
        sclk = phase_q;
      end
      default: ;
    endcase
    // inp_q/sel_q load while reset is held, so step 0 data would otherwise
    // leak out during reset.
    if (reset) sdo = 1'b0;
  end

  assign scan.scan_clk          = sclk;
  assign scan.scan_data_out     = sdo;
  assign scan.scan_select       = ssel;
  assign scan.scan_latch_enable = slat;

  // Datapath: sample chain bits in phase 0 of SHIFT_OUT, publish in DONE,
  // and register the next round's operands on entry to SHIFT_IN.
  always_comb begin
    inp_d     = inp_q;
    sel_d     = sel_q;
    result_d  = result_q;
    outputs_d = outputs_q;
    ready_d   = 1'b0;
    if (state_q == SHIFT_OUT && !phase_q && pos_hit) begin
      result_d[bit_idx] = scan.scan_data_in;
    end
    if (state_q == DONE) begin
      outputs_d = (32'(sel_q) < NUM_DESIGNS) ? result_q : '0;
      ready_d   = 1'b1;
      inp_d     = inputs;
      sel_d     = active_select;
      result_d  = '0;
    end
  end

  // Datapath registers; reset enters SHIFT_IN, so operands load here too.
  always_ff @(posedge clk) begin
    if (reset) begin
      inp_q     <= inputs;
      sel_q     <= active_select;
      result_q  <= '0;
      outputs_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      inp_q     <= inp_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      outputs_q <= outputs_d;
      ready_q   <= ready_d;
    end
  end

  assign outputs = outputs_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench: controller driving a 4-wrapper chain (lesson 1/2 alternating).
module tb_scan_chain_controller;

  localparam int unsigned ND    = 4;
  localparam int unsigned ROUND = 4 * ND * 8 + 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] active_select = '0;
  logic [7:0] inputs = '0;
  logic [7:0] outputs;
  logic       ready;

  int unsigned cycle = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [8:0]  pend_sel;
  logic [7:0]  pend_inp;
  int unsigned round_start = 0;
  logic [7:0]  latched_model [ND];
  logic [7:0]  held [ND];

  logic ck1, ck2, ck3, ck4;
  logic dt1, dt2, dt3, dt4;
  logic ss1, ss2, ss3, ss4;
  logic le1, le2, le3, le4;

  scan_chain_controller_if scan_if ();

  scan_chain_controller #(.NUM_DESIGNS(ND)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .active_select (active_select),
    .inputs        (inputs),
    .outputs       (outputs),
    .ready         (ready),
    .scan          (scan_if)
  );

  scan_wrapper_lesson_1 u_w0 (
    .clk_in(scan_if.scan_clk), .data_in(scan_if.scan_data_out),
    .scan_select_in(scan_if.scan_select), .latch_enable_in(scan_if.scan_latch_enable),
    .clk_out(ck1), .data_out(dt1), .scan_select_out(ss1), .latch_enable_out(le1));
  scan_wrapper_lesson_2 u_w1 (
    .clk_in(ck1), .data_in(dt1), .scan_select_in(ss1), .latch_enable_in(le1),
    .clk_out(ck2), .data_out(dt2), .scan_select_out(ss2), .latch_enable_out(le2));
  scan_wrapper_lesson_1 u_w2 (
    .clk_in(ck2), .data_in(dt2), .scan_select_in(ss2), .latch_enable_in(le2),
    .clk_out(ck3), .data_out(dt3), .scan_select_out(ss3), .latch_enable_out(le3));
  scan_wrapper_lesson_2 u_w3 (
    .clk_in(ck3), .data_in(dt3), .scan_select_in(ss3), .latch_enable_in(le3),
    .clk_out(ck4), .data_out(dt4), .scan_select_out(ss4), .latch_enable_out(le4));

  assign scan_if.scan_data_in = dt4;

  assign held[0] = u_w0.u_core.in_reg_q;
  assign held[1] = u_w1.u_core.in_reg_q;
  assign held[2] = u_w2.u_core.in_reg_q;
  assign held[3] = u_w3.u_core.in_reg_q;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: lesson 1 wrappers echo, lesson 2 wrappers invert, unknown -> 0.
  function automatic logic [7:0] model_out(input logic [8:0] s, input logic [7:0] d);
    if (32'(s) >= ND) return 8'h00;
    return s[0] ? ~d : d;
  endfunction

  // Waits (bounded) for ready; returns the finished round's operands and
  // records the operands the newly started round picked up.
  task automatic wait_ready(output bit ok, output int unsigned gap,
                            output logic [8:0] ds, output logic [7:0] dd);
    ok = 1'b0;
    for (int i = 0; i < int'(ROUND) + 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    gap = cycle - round_start;
    round_start = cycle;
    ds = pend_sel;
    dd = pend_inp;
    pend_sel = active_select;
    pend_inp = inputs;
    for (int w = 0; w < int'(ND); w++)
      latched_model[w] = (32'(ds) == 32'(w)) ? dd : 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    active_select = 9'd0;
    inputs = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++; if (outputs !== 8'h00) $display("FAIL reset_outputs: got %h expected 00", outputs); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
    n_checks++; if (scan_if.scan_clk !== 1'b0) $display("FAIL reset_scan_clk: got %b expected 0", scan_if.scan_clk); else n_pass++;
    n_checks++; if (scan_if.scan_data_out !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", scan_if.scan_data_out); else n_pass++;
    n_checks++; if (scan_if.scan_select !== 1'b0) $display("FAIL reset_ssel: got %b expected 0", scan_if.scan_select); else n_pass++;
    n_checks++; if (scan_if.scan_latch_enable !== 1'b0) $display("FAIL reset_latch: got %b expected 0", scan_if.scan_latch_enable); else n_pass++;
    n_checks++; if ({ck4, ss4, le4} !== 3'b000) $display("FAIL reset_chain_tail: got %b expected 000", {ck4, ss4, le4}); else n_pass++;
    reset = 1'b0;
    round_start = cycle;
    pend_sel = 9'd0;
    pend_inp = 8'hA5;
    active_select = 9'd1;
    inputs = 8'h0F;
  endtask

  task automatic test_loopback;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL first_ready_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (gap != ROUND) $display("FAIL first_ready_cycle: got %0d expected %0d", gap, ROUND); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL loopback_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
    active_select = 9'd3;
    inputs = 8'h3C;
  endtask

  task automatic test_invert_spacing;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL invert_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (gap != ROUND) $display("FAIL ready_spacing: got %0d expected %0d", gap, ROUND); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL invert_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) $display("FAIL ready_width: got %b expected 0", ready); else n_pass++;
    active_select = 9'd7;
    inputs = 8'hFF;
  endtask

  task automatic test_latched_regs;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL sel3_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL sel3_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
    for (int w = 0; w < int'(ND); w++) begin
      n_checks++;
      if (held[w] !== latched_model[w]) $display("FAIL latched_w%0d: got %h expected %h", w, held[w], latched_model[w]);
      else n_pass++;
    end
    active_select = 9'd0;
    inputs = 8'h11;
  endtask

  task automatic test_out_of_range;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL oor_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (gap != ROUND) $display("FAIL oor_spacing: got %0d expected %0d", gap, ROUND); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL oor_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
  endtask

  task automatic test_midround_change;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    repeat (100) @(negedge clk);
    inputs = 8'h22;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL mid_cur_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (outputs !== 8'h11) $display("FAIL mid_cur_out: got %h expected 11", outputs); else n_pass++;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL mid_next_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL mid_next_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
  endtask

  task automatic test_random;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    for (int r = 0; r < 8; r++) begin
      active_select = 9'($urandom_range(0, 9));
      inputs = 8'($urandom);
      wait_ready(ok, gap, ds, dd);
      n_checks++; if (!ok) $display("FAIL rand%0d_timeout: got none expected ready", r); else n_pass++;
      n_checks++; if (gap != ROUND) $display("FAIL rand%0d_spacing: got %0d expected %0d", r, gap, ROUND); else n_pass++;
      n_checks++;
      if (outputs !== model_out(ds, dd))
        $display("FAIL rand%0d_out: sel %0d in %h got %h expected %h", r, ds, dd, outputs, model_out(ds, dd));
      else n_pass++;
      for (int w = 0; w < int'(ND); w++) begin
        n_checks++;
        if (held[w] !== latched_model[w]) $display("FAIL rand%0d_latched_w%0d: got %h expected %h", r, w, held[w], latched_model[w]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midround;
    bit ok; int unsigned gap; logic [8:0] ds; logic [7:0] dd;
    wait_ready(ok, gap, ds, dd);
    repeat (20) @(negedge clk);
    active_select = 9'd3;
    inputs = 8'hC3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (outputs !== 8'h00) $display("FAIL mrst%0d_outputs: got %h expected 00", i, outputs); else n_pass++;
      n_checks++; if (ready !== 1'b0) $display("FAIL mrst%0d_ready: got %b expected 0", i, ready); else n_pass++;
      n_checks++;
      if ({scan_if.scan_clk, scan_if.scan_data_out, scan_if.scan_select, scan_if.scan_latch_enable} !== 4'b0000)
        $display("FAIL mrst%0d_scan: got %b expected 0000", i,
                 {scan_if.scan_clk, scan_if.scan_data_out, scan_if.scan_select, scan_if.scan_latch_enable});
      else n_pass++;
    end
    reset = 1'b0;
    round_start = cycle;
    pend_sel = 9'd3;
    pend_inp = 8'hC3;
    active_select = 9'd0;
    inputs = 8'h00;
    wait_ready(ok, gap, ds, dd);
    n_checks++; if (!ok) $display("FAIL mrst_timeout: got none expected ready"); else n_pass++;
    n_checks++; if (gap != ROUND) $display("FAIL mrst_ready_cycle: got %0d expected %0d", gap, ROUND); else n_pass++;
    n_checks++; if (outputs !== model_out(ds, dd)) $display("FAIL mrst_out: got %h expected %h", outputs, model_out(ds, dd)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_invert_spacing();
    test_latched_regs();
    test_out_of_range();
    test_midround_change();
    test_random();
    test_reset_midround();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_controller.md
# scan_chain_controller

Round-robin controller for a daisy-chained array of scan-wrapped user designs. Each round it does four things: shifts one 8-bit input vector into the selected design through a serial scan chain, latches it, captures every design's outputs, then shifts the chain back out. It presents the selected design's 8-bit result with a one-cycle `ready` pulse. It sits between chip top-level pins and a chain of `NUM_DESIGNS` scan wrappers. Each wrapper holds `NUM_IOS` = 8 chain flops.

## Interface
Parameters:
- `NUM_DESIGNS`, default 100: number of wrappers in the chain; chain length N = `NUM_DESIGNS`*8.

Ports:
- `clk` in, 1 bit: system clock; all logic on its rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `active_select` in, 9 bits: index of the design to drive and read.
- `inputs` in, 8 bits: vector applied to the selected design.
- `outputs` out, 8 bits: registered result of the selected design.
- `ready` out, 1 bit: one-cycle pulse; `outputs` is updated in the same cycle.
- `scan_clk` out, 1 bit: chain clock.
- `scan_data_out` out, 1 bit: serial data into wrapper 0.
- `scan_data_in` in, 1 bit: serial data from the last wrapper.
- `scan_select` out, 1 bit: capture strobe.
- `scan_latch_enable` out, 1 bit: latch strobe.

## Operation
Controller states:
- SHIFT_IN
  - On entry, register `inputs` and `active_select`; hold them for the whole round.
  - Run N steps, k = 0..N-1.
  - At step k, drive `scan_data_out` with the bit for chain position p = N-1-k.
  - p = 8·A+j, where A is the registered select and j = 0..7: drive registered `inputs[j]`.
  - Any other position: drive 0.
- LATCH: one step with `scan_latch_enable`=1.
- CAPTURE: one step with `scan_select`=1.
- SHIFT_OUT
  - N steps, k = 0..N-1, with `scan_data_out`=0.
  - At step k, before that step's rising `scan_clk`, sample `scan_data_in` as chain position N-1-k.
  - When that position is 8·A+j, store the sample into result bit j.
- DONE
  - One clk: `outputs` <= result and `ready`=1.
  - If A >= `NUM_DESIGNS`, `outputs` <= 0.
  - Next state is SHIFT_IN. Rounds repeat forever.

Wrapper behaviour (`scan_wrapper_lesson_1`, `scan_wrapper_lesson_2`):
- Chain flops c[0..7]. c[0] is nearest `data_in`; `data_out` = c[7].
- On rising `clk_in`, first matching condition wins:
  - `latch_enable_in`=1: design input register <= c; chain holds.
  - `scan_select_in`=1: c <= design outputs.
  - Otherwise: shift, c[0] <= `data_in`, c[i] <= c[i-1].
- `clk_out`, `scan_select_out` and `latch_enable_out` are combinational pass-throughs of the corresponding inputs.
- Lesson 1 core: outputs = input register (combinational loopback).
- Lesson 2 core: outputs = bitwise NOT of the input register.
- Input register resets to 0 at power-up only through the first latch; wrappers have no reset pin.

## Timing
- Every step is exactly 2 clk cycles:
  - Phase 0: `scan_clk`=0; data and strobes change.
  - Phase 1: `scan_clk`=1; the wrappers' rising edge.
- Data and strobes stay stable across both phases.
- Round length is 4N+5 clk cycles: 2N shift-in, 2 latch, 2 capture, 2N shift-out, 1 done.
- After reset deasserts, the first `ready` pulse occurs on cycle 4N+5.
- During reset, all outputs are 0: `outputs`, `ready`, `scan_clk`, `scan_data_out`, `scan_select`, `scan_latch_enable`. The state goes to SHIFT_IN step 0 with counters cleared.
- Reset mid-round abandons the round. `outputs` clears to 0, and no `ready` is emitted until a full new round completes.
- Changes to `inputs` or `active_select` mid-round take effect only in the next round.

## Structure
- Shared package holds:
  - `NUM_IOS` = 8;
  - the state enum: SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE;
  - the step-counter width, clog2(N+1).
- Controller contents: state register, step counter, phase bit, and the input, select and result registers. It holds no per-design storage.
- Natural sub-module: `scan_wrapper_core`, the generic 8-flop chain with latch, capture and pass-through. Lesson wrappers instantiate it with their own combinational core.

## Test plan
With `NUM_DESIGNS`=4 (wrappers alternating lesson_1, lesson_2, lesson_1, lesson_2), N=32:
- Select 0, `inputs`=0xA5, release reset: first `ready` at cycle 133, and `outputs`=0xA5.
- Select 1, `inputs`=0x0F: `outputs`=0xF0 on the next `ready`. Check that `ready` pulses are exactly 133 cycles apart and 1 cycle wide.
- Select 3, `inputs`=0x3C: `outputs`=0xC3. Then check the latched input registers: wrapper 3 holds 0x3C, and the other wrappers hold 0x00.
- Select 7 (out of range), `inputs`=0xFF: `outputs`=0x00 and `ready` still pulses.
- Change `inputs` from 0x11 to 0x22 mid-SHIFT_OUT: the current round reports 0x11 and the next round reports 0x22.
- Assert `reset` mid-SHIFT_IN: all outputs go to 0 on the next cycle, and the next `ready` comes 133 cycles after reset release.
